// File: rtl/rv_alu_pkg.sv
// Shared ALU control codes, RV32I opcode constants and the issue-stage bundle type.
package rv_alu_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned REG_W  = 5;

    // Compare codes keep bit 3 clear; arithmetic/logic codes set it, SUB is ADD with bit 0 set.
    typedef enum logic [3:0] {
        ALU_CMP_EQ   = 4'h0,
        ALU_CMP_NEQ  = 4'h1,
        ALU_CMP_LTS  = 4'h2,
        ALU_CMP_NLTS = 4'h3,
        ALU_CMP_LTU  = 4'h4,
        ALU_CMP_NLTU = 4'h5,
        ALU_ADD      = 4'h8,
        ALU_SUB      = 4'h9,
        ALU_SHL      = 4'hA,
        ALU_SHR      = 4'hB,
        ALU_XOR      = 4'hC,
        ALU_OR       = 4'hD,
        ALU_AND      = 4'hE
    } alu_op_e;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN_W-1:0] src_a;
        logic [XLEN_W-1:0] src_b;
        logic [XLEN_W-1:0] imm;
        logic [XLEN_W-1:0] pc;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  rd;
        logic              rd_we;
        logic              branch;
        logic              jump;
    } alu_bundle_t;

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic sra, input alu_op_e op);
        return {sra, 4'(op)};
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), all sign-extended to 32 bits.
module rv_imm_gen
    import rv_alu_pkg::*;
(
    input  logic [31:7]       instr,
    output logic [XLEN_W-1:0] imm_i_c,
    output logic [XLEN_W-1:0] imm_s_c,
    output logic [XLEN_W-1:0] imm_b_c,
    output logic [XLEN_W-1:0] imm_u_c,
    output logic [XLEN_W-1:0] imm_j_c
);

    assign imm_i_c = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_c = {instr[31:12], 12'h000};
    assign imm_j_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/rv_alu_dec.sv
// RV32I decode/issue stage: builds the ALU operand/control bundle and holds it in a
// one-entry valid/ready pipeline register. Define RV_ALU_DEC_ILLEGAL_EN to add o_illegal.
module rv_alu_dec
    import rv_alu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_src_a,
    output logic [XLEN-1:0]   o_src_b,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [XLEN-1:0]   o_imm,
    output logic [XLEN-1:0]   o_pc,
    output logic [REG_W-1:0]  o_rd,
    output logic              o_rd_we,
    output logic              o_branch,
    output logic              o_jump
`ifdef RV_ALU_DEC_ILLEGAL_EN
    ,
    output logic              o_illegal
`endif
);

    if (XLEN != XLEN_W) begin : g_xlen_check
        $error("rv_alu_dec: only XLEN=32 is supported");
    end

    localparam alu_bundle_t RESET_BUNDLE = '{
        src_a:  '0,
        src_b:  '0,
        imm:    '0,
        pc:     RESET_PC,
        ctrl:   mk_ctrl(1'b0, ALU_ADD),
        rd:     '0,
        rd_we:  1'b0,
        branch: 1'b0,
        jump:   1'b0
    };

    logic [OPC_W-1:0]  opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_W-1:0]  rd;
    logic [4:0]        shamt;
    logic              is_op;
    logic              f7_ok;
    logic              f7_zero;
    logic [XLEN_W-1:0] imm_i;
    logic [XLEN_W-1:0] imm_s;
    logic [XLEN_W-1:0] imm_b;
    logic [XLEN_W-1:0] imm_u;
    logic [XLEN_W-1:0] imm_j;

    alu_op_e           op;
    logic              sra;
    logic              bad;
    alu_bundle_t       dec_c;
    alu_bundle_t       bundle_q;
    logic              valid_q;
    logic              load;

    assign opcode  = i_instr[6:0];
    assign rd      = i_instr[11:7];
    assign funct3  = i_instr[14:12];
    assign shamt   = i_instr[24:20];
    assign funct7  = i_instr[31:25];
    assign is_op   = (opcode == OPC_OP);
    assign f7_zero = (funct7 == F7_ZERO);
    assign f7_ok   = f7_zero || (funct7 == F7_ALT);

    rv_imm_gen u_imm_gen (
        .instr   (i_instr[31:7]),
        .imm_i_c (imm_i),
        .imm_s_c (imm_s),
        .imm_b_c (imm_b),
        .imm_u_c (imm_u),
        .imm_j_c (imm_j)
    );

    // Opcode/funct decode; any illegal encoding collapses to the NOP bundle.
    always_comb begin
        op           = ALU_ADD;
        sra          = 1'b0;
        bad          = 1'b0;
        dec_c        = '0;
        dec_c.pc     = i_pc;
        dec_c.rd     = rd;

        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_c.src_a = i_rs1_data;
                dec_c.rd_we = 1'b1;
                if (is_op) begin
                    dec_c.src_b = i_rs2_data;
                end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_c.src_b = XLEN_W'(shamt);
                    dec_c.imm   = imm_i;
                end else begin
                    dec_c.src_b = imm_i;
                    dec_c.imm   = imm_i;
                end
                case (funct3)
                    3'b000: begin
                        if (is_op && i_instr[30]) op = ALU_SUB;
                        else                      op = ALU_ADD;
                        bad = is_op && !f7_ok;
                    end
                    3'b001: begin
                        op  = ALU_SHL;
                        bad = !f7_zero;
                    end
                    3'b010: begin
                        op  = ALU_CMP_LTS;
                        bad = is_op && !f7_zero;
                    end
                    3'b011: begin
                        op  = ALU_CMP_LTU;
                        bad = is_op && !f7_zero;
                    end
                    3'b100: begin
                        op  = ALU_XOR;
                        bad = is_op && !f7_zero;
                    end
                    3'b101: begin
                        op  = ALU_SHR;
                        sra = i_instr[30];
                        bad = !f7_ok;
                    end
                    3'b110: begin
                        op  = ALU_OR;
                        bad = is_op && !f7_zero;
                    end
                    default: begin
                        op  = ALU_AND;
                        bad = is_op && !f7_zero;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_c.src_b = imm_u;
                dec_c.imm   = imm_u;
                dec_c.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.src_a = i_pc;
                dec_c.src_b = imm_u;
                dec_c.imm   = imm_u;
                dec_c.rd_we = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_c.src_a = i_pc;
                dec_c.src_b = XLEN_W'(4);
                dec_c.rd_we = 1'b1;
                dec_c.jump  = 1'b1;
                dec_c.imm   = (opcode == OPC_JAL) ? imm_j : imm_i;
                bad         = (opcode == OPC_JALR) && (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_c.src_a  = i_rs1_data;
                dec_c.src_b  = i_rs2_data;
                dec_c.imm    = imm_b;
                dec_c.branch = 1'b1;
                case (funct3)
                    3'b000:  op = ALU_CMP_EQ;
                    3'b001:  op = ALU_CMP_NEQ;
                    3'b100:  op = ALU_CMP_LTS;
                    3'b101:  op = ALU_CMP_NLTS;
                    3'b110:  op = ALU_CMP_LTU;
                    3'b111:  op = ALU_CMP_NLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_c.src_a = i_rs1_data;
                dec_c.src_b = imm_i;
                dec_c.imm   = imm_i;
                dec_c.rd_we = 1'b1;
                bad         = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec_c.src_a = i_rs1_data;
                dec_c.src_b = imm_s;
                dec_c.imm   = imm_s;
                bad         = (funct3 > 3'b010);
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            op           = ALU_ADD;
            sra          = 1'b0;
            dec_c.src_a  = '0;
            dec_c.src_b  = '0;
            dec_c.imm    = '0;
            dec_c.rd_we  = 1'b0;
            dec_c.branch = 1'b0;
            dec_c.jump   = 1'b0;
        end
        if (rd == '0) dec_c.rd_we = 1'b0;
        dec_c.ctrl = mk_ctrl(sra, op);
    end

    assign o_ready = !valid_q || i_ready;
    assign load    = i_valid && o_ready && !i_flush;

    // One-entry pipeline register; flush wins over load and over a pending transfer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q  <= 1'b0;
            bundle_q <= RESET_BUNDLE;
        end else begin
            if (i_flush)      valid_q <= 1'b0;
            else if (load)    valid_q <= 1'b1;
            else if (i_ready) valid_q <= 1'b0;
            if (load) bundle_q <= dec_c;
        end
    end

`ifdef RV_ALU_DEC_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)  illegal_q <= 1'b0;
        else if (load)   illegal_q <= bad;
    end

    assign o_illegal = illegal_q;
`endif

    assign o_valid  = valid_q;
    assign o_src_a  = bundle_q.src_a;
    assign o_src_b  = bundle_q.src_b;
    assign o_ctrl   = bundle_q.ctrl;
    assign o_imm    = bundle_q.imm;
    assign o_pc     = bundle_q.pc;
    assign o_rd     = bundle_q.rd;
    assign o_rd_we  = bundle_q.rd_we;
    assign o_branch = bundle_q.branch;
    assign o_jump   = bundle_q.jump;

endmodule

// File: tb/tb_rv_alu_dec.sv
// Scoreboard bench for rv_alu_dec: expected bundles queued on accept, compared on transfer.
module tb_rv_alu_dec;
    import rv_alu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] imm;
        logic [4:0]  ctrl;
        logic [4:0]  rd;
        logic        rd_we;
        logic        branch;
        logic        jump;
        logic        ill;
        logic        chk_src;
        logic        chk_imm;
    } tv_t;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_src_a;
    logic [31:0] o_src_b;
    logic [4:0]  o_ctrl;
    logic [31:0] o_imm;
    logic [31:0] o_pc;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic        o_branch;
    logic        o_jump;
`ifdef RV_ALU_DEC_ILLEGAL_EN
    logic        o_illegal;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    tv_t  tbl[$];
    tv_t  sb[$];
    tv_t  idle = '{default: '0};

    rv_alu_dec #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_src_a    (o_src_a),
        .o_src_b    (o_src_b),
        .o_ctrl     (o_ctrl),
        .o_imm      (o_imm),
        .o_pc       (o_pc),
        .o_rd       (o_rd),
        .o_rd_we    (o_rd_we),
        .o_branch   (o_branch),
        .o_jump     (o_jump)
`ifdef RV_ALU_DEC_ILLEGAL_EN
        ,
        .o_illegal  (o_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic tv_t tv(input logic [31:0] instr, pc, rs1, rs2, src_a, src_b, imm,
                               input logic [4:0] ctrl, rd,
                               input logic rd_we, branch, jump, ill, chk_src, chk_imm);
        tv_t t;
        t.instr = instr; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2;
        t.src_a = src_a; t.src_b = src_b; t.imm = imm; t.ctrl = ctrl; t.rd = rd;
        t.rd_we = rd_we; t.branch = branch; t.jump = jump; t.ill = ill;
        t.chk_src = chk_src; t.chk_imm = chk_imm;
        return t;
    endfunction

    task automatic drive(input tv_t t);
        i_instr    = t.instr;
        i_pc       = t.pc;
        i_rs1_data = t.rs1;
        i_rs2_data = t.rs2;
    endtask

    task automatic compare(input tv_t e);
        if (e.chk_src) begin
            check("src_a", o_src_a, e.src_a);
            check("src_b", o_src_b, e.src_b);
        end
        if (e.chk_imm) check("imm", o_imm, e.imm);
        if (e.rd_we)   check("rd", 32'(o_rd), 32'(e.rd));
        check("ctrl", 32'(o_ctrl), 32'(e.ctrl));
        check("rd_we", 32'(o_rd_we), 32'(e.rd_we));
        check("branch", 32'(o_branch), 32'(e.branch));
        check("jump", 32'(o_jump), 32'(e.jump));
        check("pc", o_pc, e.pc);
`ifdef RV_ALU_DEC_ILLEGAL_EN
        check("illegal", 32'(o_illegal), 32'(e.ill));
`endif
    endtask

    // One cycle: observe mid-cycle, score the edge's transfer/accept, advance past the edge.
    task automatic step(input tv_t cur, output bit acc);
        tv_t e;
        #1;
        acc = i_valid && o_ready && !i_flush;
        if (o_valid && (i_ready || i_flush)) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                if (!i_flush) compare(e);
            end
        end
        if (acc) sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int guard;

        // instr, pc, rs1, rs2, src_a, src_b, imm, ctrl, rd, we, br, j, ill, chk_src, chk_imm
        tbl.push_back(tv(32'h002081B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 0, {1'b0, ALU_ADD}, 5'd3, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h402081B3, 32'h104, 32'd5, 32'd7, 32'd5, 32'd7, 0, {1'b0, ALU_SUB}, 5'd3, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h4030D093, 32'h108, 32'h80000000, 0, 32'h80000000, 32'd3, 0, {1'b1, ALU_SHR}, 5'd1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h0030D093, 32'h10C, 32'h80000000, 0, 32'h80000000, 32'd3, 0, {1'b0, ALU_SHR}, 5'd1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h0020F463, 32'h110, 32'd10, 32'd20, 32'd10, 32'd20, 32'd8, {1'b0, ALU_CMP_NLTU}, 5'd8, 0, 1, 0, 0, 1, 1));
        tbl.push_back(tv(32'h123452B7, 32'h114, 32'd11, 32'd22, 32'd0, 32'h12345000, 0, {1'b0, ALU_ADD}, 5'd5, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h00001317, 32'h200, 0, 0, 32'h200, 32'h1000, 0, {1'b0, ALU_ADD}, 5'd6, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h010000EF, 32'h300, 0, 0, 32'h300, 32'd4, 32'd16, {1'b0, ALU_ADD}, 5'd1, 1, 0, 1, 0, 1, 1));
        tbl.push_back(tv(32'h00008067, 32'h304, 32'h40, 0, 32'h304, 32'd4, 32'd0, {1'b0, ALU_ADD}, 5'd0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(tv(32'hFFC12383, 32'h308, 32'h1000, 0, 32'h1000, 32'hFFFFFFFC, 0, {1'b0, ALU_ADD}, 5'd7, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h00512623, 32'h30C, 32'h1000, 32'h55, 32'h1000, 32'd12, 32'd12, {1'b0, ALU_ADD}, 5'd12, 0, 0, 0, 0, 1, 1));
        tbl.push_back(tv(32'h00500013, 32'h310, 32'd9, 0, 32'd9, 32'd5, 0, {1'b0, ALU_ADD}, 5'd0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h0000007F, 32'h314, 32'd1, 32'd2, 0, 0, 0, {1'b0, ALU_ADD}, 5'd0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(tv(32'h0020A463, 32'h318, 32'd3, 32'd3, 0, 0, 0, {1'b0, ALU_ADD}, 5'd8, 0, 0, 0, 1, 0, 0));
        tbl.push_back(tv(32'h0020A233, 32'h31C, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 0, {1'b0, ALU_CMP_LTS}, 5'd4, 1, 0, 0, 0, 1, 0));
        tbl.push_back(tv(32'h4020D1B3, 32'h320, 32'h80000000, 32'd4, 32'h80000000, 32'd4, 0, {1'b1, ALU_SHR}, 5'd3, 1, 0, 0, 0, 1, 0));

        // Reset values observed while reset is held
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_pc", o_pc, RST_PC);
        check("rst_ctrl", 32'(o_ctrl), 32'({1'b0, ALU_ADD}));
        check("rst_src_a", o_src_a, 32'd0);
        check("rst_rd_we", 32'(o_rd_we), 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step(idle, acc);
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_ready", 32'(o_ready), 32'd1);
        check("idle_pc", o_pc, RST_PC);

        // Stream the table with random downstream backpressure
        foreach (tbl[i]) begin
            drive(tbl[i]);
            i_valid = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 10) begin
                i_ready = ($urandom_range(0, 3) != 0);
                step(tbl[i], acc);
                guard++;
            end
            if (!acc) check("accept_timeout", 32'd0, 32'd1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step(idle, acc);
            guard++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(o_valid), 32'd0);

        // Stall for three cycles: held bundle must stay frozen and input must not load
        i_ready = 1'b0;
        drive(tbl[0]);
        i_valid = 1'b1;
        step(tbl[0], acc);
        check("bp_load_a", 32'(acc), 32'd1);
        drive(tbl[1]);
        repeat (3) begin
            step(tbl[1], acc);
            check("bp_noacc", 32'(acc), 32'd0);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ctrl", 32'(o_ctrl), 32'(tbl[0].ctrl));
            check("bp_src_b", o_src_b, tbl[0].src_b);
        end
        i_ready = 1'b1;
        step(tbl[1], acc);
        check("bp_load_b", 32'(acc), 32'd1);

        // Flush while stalled drops the held bundle and the incoming one
        i_ready = 1'b0;
        drive(tbl[2]);
        i_flush = 1'b1;
        step(tbl[2], acc);
        check("flush_noacc", 32'(acc), 32'd0);
        check("flush_valid", 32'(o_valid), 32'd0);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        step(idle, acc);
        check("post_flush_valid", 32'(o_valid), 32'd0);
        check("post_flush_sb", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_alu_dec.md
Name: rv_alu_dec

Overview:
- Decode/issue stage that produces the ALU operand and control bundle: {src_a, src_b, 5-bit ctrl}.
- Sits between register-file read and the combinational ALU.
- Decodes RV32I ALU-relevant opcodes (OP, OP-IMM, LUI, AUIPC, BRANCH, JAL, JALR, LOAD, STORE) into ALU ctrl codes and operands.
- Registers the result in a one-entry pipeline register with valid/ready handshake and flush.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; any other value is an elaboration error.
- RESET_PC, 32'h0000_0000, reset value of o_pc.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept
- i_instr  in  32  instruction word
- i_pc  in  32  instruction PC
- i_rs1_data  in  32  register rs1 value
- i_rs2_data  in  32  register rs2 value
- i_flush  in  1  kill held and incoming instruction
- o_valid  out  1  bundle valid
- i_ready  in  1  downstream accepts
- o_src_a  out  32  ALU operand A
- o_src_b  out  32  ALU operand B
- o_ctrl  out  5  ALU control; [3:0] op code, [4] arithmetic-shift select
- o_imm  out  32  sign-extended immediate (branch/store offset)
- o_pc  out  32  registered PC
- o_rd  out  5  destination register
- o_rd_we  out  1  register writeback enable
- o_branch  out  1  conditional branch; ALU result is the taken flag
- o_jump  out  1  JAL/JALR

Behaviour:
- Reset (async, i_reset_n=0):
  - o_valid=0; o_src_a, o_src_b, o_imm, o_rd=0; o_pc=RESET_PC.
  - o_ctrl=ADD code; o_rd_we, o_branch, o_jump=0.
- Handshake:
  - o_ready = !o_valid | i_ready (combinational).
  - Load when i_valid & o_ready; latency one cycle.
  - Hold all outputs stable while o_valid & !i_ready.
  - When o_valid & i_ready & !load, o_valid clears next cycle.
- Flush:
  - i_flush=1 clears o_valid next cycle regardless of i_valid or i_ready.
  - No instruction is loaded that cycle.
  - Flush has priority over load.
- Decode (ctrl names come from the shared package):
  - OP (0110011):
    - src_a=rs1, src_b=rs2.
    - funct3 000 → ADD, or SUB when instr[30].
    - 001 → SHL; 100 → XOR; 110 → OR; 111 → AND.
    - 101 → SHR, with ctrl[4]=instr[30].
    - 010 → CMP_LTS; 011 → CMP_LTU.
    - rd_we=1.
  - OP-IMM (0010011): same mapping with src_b=I-imm. instr[30] selects SUB never; it selects only SRAI.
  - LUI: src_a=0, src_b=U-imm, ADD.
  - AUIPC: src_a=pc, src_b=U-imm, ADD.
  - JAL/JALR: src_a=pc, src_b=4, ADD, rd_we=1, jump=1. o_imm=J-imm or I-imm.
  - BRANCH:
    - src_a=rs1, src_b=rs2, rd_we=0, branch=1, o_imm=B-imm.
    - funct3 000 EQ, 001 NEQ, 100 LTS, 101 NLTS, 110 LTU, 111 NLTU.
  - LOAD/STORE: src_a=rs1, src_b=I-imm / S-imm, ADD. rd_we=1 for LOAD only.
- Invariants and defaults:
  - ctrl[4]=0 except SRA/SRAI.
  - Compare codes have ctrl[3]=0; arithmetic codes have ctrl[3]=1.
  - ADD has ctrl[0]=0; SUB has ctrl[0]=1.
  - Unknown opcode, or branch funct3 010/011: NOP bundle (ADD, rd_we=0, branch=0, jump=0).
  - rd=0 forces rd_we=0.

Optional Feature:
- Macro: RV_ALU_DEC_ILLEGAL_EN.
- Defined:
  - Adds output port o_illegal (1 bit, reset 0).
  - o_illegal is set for unknown opcode, bad funct3, or a nonzero funct7 other than 0100000 on legal SUB/SRA(I) positions.
  - It is registered with the bundle.
- Undefined:
  - No port.
  - Illegal encodings silently decode to the NOP bundle.

Decomposition:
- Package rv_alu_pkg:
  - ALU ctrl codes (ADD, SUB, XOR, OR, AND, SHL, SHR, CMP_EQ/NEQ/LTS/NLTS/LTU/NLTU), values identical to the existing ALU defines.
  - Opcode constants.
  - Typedef alu_bundle_t.
- Sub-module rv_imm_gen (combinational I/S/B/U/J immediate extraction). The pipeline register and handshake stay in rv_alu_dec.

Test Plan:
- Reset, then idle → o_valid=0, o_ready=1, o_pc=RESET_PC.
- ADD then SUB:
  - Stimulus: instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, i_ready=1 → next cycle src_a=5, src_b=7, ctrl=ADD, rd=3, rd_we=1.
  - Stimulus: instr 0x402081B3 → ctrl=SUB.
- SRAI:
  - Stimulus: 0x4030D093, rs1=0x80000000 → src_b=3, ctrl[4]=1, ctrl[3:0]=SHR.
  - Same stimulus with 0x0030D093 → ctrl[4]=0.
- BGEU:
  - Stimulus: 0x0020F463 → ctrl=CMP_NLTU, branch=1, rd_we=0, o_imm=8.
- Backpressure:
  - Stimulus: i_ready=0 for 3 cycles with i_valid=1.
  - Response: o_ready=0 and outputs frozen.
  - After i_ready=1, the next instruction loads.
  - Flush asserted while stalled clears o_valid next cycle.
- Illegal opcode 0x0000007F → rd_we=0, ctrl=ADD. With RV_ALU_DEC_ILLEGAL_EN, o_illegal=1.
